// File: rtl/gp_lpddr5_ca_decoder.sv
// LPDDR5 CS/CA command decoder: merges two- and four-beat commands into a transaction FIFO.
// Optional refresh watchdog enabled by defining GP_LPDDR5_REF_WATCHDOG_EN.
module gp_lpddr5_ca_decoder #(
  parameter int FIFO_DEPTH   = 4,
  parameter int TREFI_CYCLES = 3900
) (
  input  logic                          ck_t,
  input  logic                          ddr_reset_n,
  input  logic                          cs,
  input  logic [6:0]                    ca,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [4:0]                    cmd_code,
  output logic [27:0]                   cmd_payload,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wck_sync,
  output logic                          err_illegal,
  output logic                          err_overflow,
  output logic                          err_refresh
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BEAT2, S_WAIT2, S_BEAT4} state_e;

  // ACT and MRW double as the first half of their pairs; ACT2/MRW2 only ever appear as beat 3.
  typedef enum logic [4:0] {
    OP_ILL = 5'd0,  OP_ACT = 5'd1,  OP_RD16 = 5'd2,  OP_RD32 = 5'd3,
    OP_WR16 = 5'd4, OP_WR32 = 5'd5, OP_MWR = 5'd6,   OP_CAS = 5'd7,
    OP_MRW = 5'd8,  OP_MRR = 5'd9,  OP_REF = 5'd10,  OP_PRE = 5'd11,
    OP_SRE = 5'd12, OP_MPC = 5'd13, OP_WFF = 5'd14,  OP_RFF = 5'd15,
    OP_PDE = 5'd16, OP_ACT2 = 5'd17, OP_MRW2 = 5'd18
  } op_e;

  function automatic op_e decodeOp(input logic [6:0] b);
    op_e op;
    casez (b)
      7'b111????: op = OP_ACT;
      7'b110????: op = OP_ACT2;
      7'b100????: op = OP_RD16;
      7'b101????: op = OP_RD32;
      7'b011????: op = OP_WR16;
      7'b010????: op = OP_MWR;
      7'b0010???: op = OP_WR32;
      7'b0011???: op = OP_CAS;
      7'b0001101: op = OP_MRW;
      7'b000100?: op = OP_MRW2;
      7'b0001100: op = OP_MRR;
      7'b0001110: op = OP_REF;
      7'b0001111: op = OP_PRE;
      7'b0001011: op = OP_SRE;
      7'b000011?: op = OP_MPC;
      7'b0000011: op = OP_WFF;
      7'b0000010: op = OP_RFF;
      7'b0000001: op = OP_PDE;
      default:    op = OP_ILL;
    endcase
    return op;
  endfunction

  state_e      state_q;
  logic [6:0]  beat1_q, beat2_q, beat3_q;
  logic        err_illegal_q, wck_sync_q;

  op_e         op1, opNow;
  logic        illegal1, pairOk;
  logic        push;
  op_e         pushCode;
  logic [27:0] pushPayload;

  always_comb begin
    op1         = decodeOp(beat1_q);
    opNow       = decodeOp(ca);
    illegal1    = (op1 == OP_ILL) || (op1 == OP_ACT2) || (op1 == OP_MRW2);
    pairOk      = cs && (((op1 == OP_ACT) && (opNow == OP_ACT2)) ||
                         ((op1 == OP_MRW) && (opNow == OP_MRW2)));
    push        = 1'b0;
    pushCode    = OP_ILL;
    pushPayload = '0;
    case (state_q)
      S_BEAT2: begin
        if (!illegal1 && (op1 != OP_ACT) && (op1 != OP_MRW)) begin
          push        = 1'b1;
          pushCode    = op1;
          pushPayload = {beat1_q, ca, 14'h0};
        end
      end
      S_BEAT4: begin
        push        = 1'b1;
        pushCode    = op1;
        pushPayload = {beat1_q, beat2_q, beat3_q, ca};
      end
      default: ;
    endcase
  end

  // Command FSM; a failed pair whose beat has cs=1 is restarted as a new beat 1.
  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      state_q       <= S_IDLE;
      beat1_q       <= '0;
      beat2_q       <= '0;
      beat3_q       <= '0;
      err_illegal_q <= 1'b0;
      wck_sync_q    <= 1'b0;
    end else begin
      err_illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cs) begin
            beat1_q <= ca;
            state_q <= S_BEAT2;
          end
        end
        S_BEAT2: begin
          beat2_q <= ca;
          if (illegal1) begin
            err_illegal_q <= 1'b1;
            state_q       <= S_IDLE;
          end else if ((op1 == OP_ACT) || (op1 == OP_MRW)) begin
            state_q <= S_WAIT2;
          end else begin
            state_q <= S_IDLE;
          end
          if (push && (op1 == OP_CAS)) begin
            case (beat1_q[2:0])
              3'b100, 3'b010, 3'b001: wck_sync_q <= 1'b1;
              3'b111:                 wck_sync_q <= 1'b0;
              default: ;
            endcase
          end
        end
        S_WAIT2: begin
          if (pairOk) begin
            beat3_q <= ca;
            state_q <= S_BEAT4;
          end else begin
            err_illegal_q <= 1'b1;
            if (cs) begin
              beat1_q <= ca;
              state_q <= S_BEAT2;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_BEAT4: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [LW-1:0] count_q;
  logic          err_overflow_q;
  logic          pop, full, accept;

  assign pop    = (count_q != '0) && cmd_ready;
  assign full   = (count_q == FULL_LVL);
  assign accept = push && (!full || pop);

  // A push into a full FIFO only succeeds when the head leaves on the same edge.
  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      count_q        <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      err_overflow_q <= push && full && !pop;
      if (accept) begin
        mem_q[wrPtr_q] <= {pushCode, pushPayload};
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (!accept && pop) count_q <= count_q - 1'b1;
    end
  end

  assign cmd_valid              = (count_q != '0);
  assign {cmd_code, cmd_payload} = mem_q[rdPtr_q];
  assign fifo_level             = count_q;
  assign wck_sync               = wck_sync_q;
  assign err_illegal            = err_illegal_q;
  assign err_overflow           = err_overflow_q;

`ifdef GP_LPDDR5_REF_WATCHDOG_EN
  localparam int WD_LIMIT = 2 * TREFI_CYCLES;
  localparam int WDW      = $clog2(WD_LIMIT + 1);

  logic [WDW-1:0] wdog_q;
  logic           sreHold_q, err_refresh_q;

  // Self-refresh parks the counter at zero until a non-SRE command is pushed.
  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      wdog_q        <= '0;
      sreHold_q     <= 1'b0;
      err_refresh_q <= 1'b0;
    end else begin
      err_refresh_q <= 1'b0;
      if (accept) sreHold_q <= (pushCode == OP_SRE);
      if ((accept && ((pushCode == OP_SRE) || (pushCode == OP_REF))) ||
          (sreHold_q && !accept)) begin
        wdog_q <= '0;
      end else if (wdog_q == WDW'(WD_LIMIT - 1)) begin
        wdog_q        <= '0;
        err_refresh_q <= 1'b1;
      end else begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end

  assign err_refresh = err_refresh_q;
`else
  assign err_refresh = (TREFI_CYCLES < 0);
`endif

endmodule

// File: tb/tb_gp_lpddr5_ca_decoder.sv
// Directed bench for gp_lpddr5_ca_decoder; refresh watchdog checks run when
// GP_LPDDR5_REF_WATCHDOG_EN is defined.
module tb_gp_lpddr5_ca_decoder;

  localparam int DEPTH = 4;

  logic        ck_t = 1'b0;
  logic        ddr_reset_n;
  logic        cs;
  logic [6:0]  ca;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_code;
  logic [27:0] cmd_payload;
  logic [2:0]  fifo_level;
  logic        wck_sync, err_illegal, err_overflow, err_refresh;

  int nChecks = 0;
  int nFail   = 0;
  int ovfPulses = 0;
  int refPulses = 0;

  gp_lpddr5_ca_decoder #(.FIFO_DEPTH(DEPTH), .TREFI_CYCLES(8)) dut (
    .ck_t(ck_t), .ddr_reset_n(ddr_reset_n), .cs(cs), .ca(ca),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_payload(cmd_payload), .fifo_level(fifo_level), .wck_sync(wck_sync),
    .err_illegal(err_illegal), .err_overflow(err_overflow), .err_refresh(err_refresh)
  );

  always #5 ck_t = ~ck_t;

  always @(negedge ck_t) begin
    if (err_overflow === 1'b1) ovfPulses++;
    if (err_refresh === 1'b1) refPulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one beat and returns just after the edge that samples it.
  task automatic applyStimulus(input logic c, input logic [6:0] a);
    cs = c;
    ca = a;
    @(posedge ck_t);
    #1;
  endtask

  task automatic resetDut();
    ddr_reset_n = 1'b0;
    cs = 1'b0;
    ca = '0;
    repeat (2) @(posedge ck_t);
    #1;
    ddr_reset_n = 1'b1;
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    repeat (DEPTH) applyStimulus(1'b0, 7'h00);
    cmd_ready = 1'b0;
  endtask

  function automatic logic [27:0] pl2(input logic [6:0] b1, input logic [6:0] b2);
    return {b1, b2, 14'h0};
  endfunction

  initial begin
    cmd_ready = 1'b0;
    resetDut();
    checkOutput("rst_valid", cmd_valid, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_code", cmd_code, 0);
    checkOutput("rst_payload", cmd_payload, 0);
    checkOutput("rst_errs", {wck_sync, err_illegal, err_overflow, err_refresh}, 0);

    cmd_ready = 1'b1;
    applyStimulus(1'b1, 7'b0001111);
    checkOutput("pre_early", cmd_valid, 0);
    applyStimulus(1'b0, 7'b0000101);
    checkOutput("pre_valid", cmd_valid, 1);
    checkOutput("pre_code", cmd_code, 11);
    checkOutput("pre_payload", cmd_payload, pl2(7'h0F, 7'h05));
    checkOutput("pre_level", fifo_level, 1);
    applyStimulus(1'b0, 7'h00);
    checkOutput("pre_popped", cmd_valid, 0);
    cmd_ready = 1'b0;

    applyStimulus(1'b1, 7'b1110010);
    applyStimulus(1'b0, 7'b0000001);
    checkOutput("act_wait_lvl", fifo_level, 0);
    applyStimulus(1'b1, 7'b1100011);
    checkOutput("act_b3_lvl", fifo_level, 0);
    applyStimulus(1'b0, 7'b0000100);
    checkOutput("act_valid", cmd_valid, 1);
    checkOutput("act_code", cmd_code, 1);
    checkOutput("act_payload", cmd_payload, {7'h72, 7'h01, 7'h63, 7'h04});
    checkOutput("act_no_err", err_illegal, 0);
    applyStimulus(1'b0, 7'h00);
    checkOutput("act_stable", cmd_payload, {7'h72, 7'h01, 7'h63, 7'h04});
    drain();
    checkOutput("act_drained", fifo_level, 0);

    applyStimulus(1'b1, 7'b1110010);
    applyStimulus(1'b0, 7'b0000001);
    applyStimulus(1'b1, 7'b0001110);
    checkOutput("brk_err", err_illegal, 1);
    checkOutput("brk_lvl", fifo_level, 0);
    applyStimulus(1'b0, 7'b0000011);
    checkOutput("brk_err_off", err_illegal, 0);
    checkOutput("brk_ref_lvl", fifo_level, 1);
    checkOutput("brk_ref_code", cmd_code, 10);
    checkOutput("brk_ref_pl", cmd_payload, pl2(7'h0E, 7'h03));
    drain();

    ovfPulses = 0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 7'b0001111);
      applyStimulus(1'b0, 7'(i));
    end
    checkOutput("ovf_level", fifo_level, 4);
    checkOutput("ovf_pulse", err_overflow, 1);
    applyStimulus(1'b0, 7'h00);
    checkOutput("ovf_pulse_off", err_overflow, 0);
    checkOutput("ovf_count", ovfPulses, 1);
    cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("ovf_order%0d", i), cmd_payload, pl2(7'h0F, 7'(i)));
      applyStimulus(1'b0, 7'h00);
    end
    checkOutput("ovf_empty", fifo_level, 0);
    cmd_ready = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 7'b0001111);
      applyStimulus(1'b0, 7'(8 + i));
    end
    ovfPulses = 0;
    applyStimulus(1'b1, 7'b0001111);
    cmd_ready = 1'b1;
    applyStimulus(1'b0, 7'h0D);
    cmd_ready = 1'b0;
    checkOutput("fullpop_lvl", fifo_level, 4);
    checkOutput("fullpop_head", cmd_payload, pl2(7'h0F, 7'h0A));
    applyStimulus(1'b0, 7'h00);
    checkOutput("fullpop_no_ovf", ovfPulses, 0);
    cmd_ready = 1'b1;
    repeat (3) applyStimulus(1'b0, 7'h00);
    checkOutput("fullpop_tail", cmd_payload, pl2(7'h0F, 7'h0D));
    applyStimulus(1'b0, 7'h00);
    checkOutput("fullpop_empty", fifo_level, 0);

    applyStimulus(1'b1, 7'b0011001);
    applyStimulus(1'b0, 7'h00);
    checkOutput("cas_fs_sync", wck_sync, 1);
    checkOutput("cas_code", cmd_code, 7);
    applyStimulus(1'b1, 7'b0011011);
    applyStimulus(1'b0, 7'h00);
    checkOutput("cas_other_sync", wck_sync, 1);
    applyStimulus(1'b1, 7'b0011111);
    applyStimulus(1'b0, 7'h00);
    checkOutput("cas_off_sync", wck_sync, 0);
    applyStimulus(1'b0, 7'h00);

    applyStimulus(1'b1, 7'b0000101);
    applyStimulus(1'b0, 7'h00);
    checkOutput("ill_err", err_illegal, 1);
    checkOutput("ill_lvl", fifo_level, 0);
    applyStimulus(1'b0, 7'h00);
    checkOutput("ill_err_off", err_illegal, 0);
    applyStimulus(1'b1, 7'b1100000);
    applyStimulus(1'b0, 7'h00);
    checkOutput("lone_act2_err", err_illegal, 1);
    checkOutput("lone_act2_lvl", fifo_level, 0);
    cmd_ready = 1'b0;

    applyStimulus(1'b1, 7'b1110010);
    applyStimulus(1'b0, 7'b0000001);
    ddr_reset_n = 1'b0;
    #2;
    checkOutput("midrst_lvl", fifo_level, 0);
    ddr_reset_n = 1'b1;
    applyStimulus(1'b1, 7'b1100011);
    applyStimulus(1'b0, 7'b0000100);
    checkOutput("midrst_err", err_illegal, 1);
    checkOutput("midrst_nopush", fifo_level, 0);

`ifdef GP_LPDDR5_REF_WATCHDOG_EN
    resetDut();
    cmd_ready = 1'b1;
    refPulses = 0;
    repeat (15) applyStimulus(1'b0, 7'h00);
    checkOutput("wd_early", refPulses, 0);
    applyStimulus(1'b0, 7'h00);
    checkOutput("wd_fire", err_refresh, 1);
    applyStimulus(1'b0, 7'h00);
    checkOutput("wd_fire_off", err_refresh, 0);
    checkOutput("wd_pulses", refPulses, 1);
    resetDut();
    refPulses = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 7'b0001110);
      applyStimulus(1'b0, 7'h00);
      repeat (8) applyStimulus(1'b0, 7'h00);
    end
    checkOutput("wd_ref_ok", refPulses, 0);
`else
    refPulses = 0;
    repeat (20) applyStimulus(1'b0, 7'h00);
    checkOutput("wd_absent", refPulses, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
